twowire_host_connect_gen: RTL and testbench

// Host-side generator of the Two-Wire Debug Connect sequence: the transmit end matching
// the DTM connect monitor. On request it serialises, one bit per bit_en strobe onto DIO:
// - a zero preamble;
// - 64 bits of the 6-bit connect LFSR;
// - 72 ones;
// - the 4-bit target address, then its complement.

---
 rtl/twowire_host_connect_gen.sv | 126 ++++++++++++
 tb/tb_twowire_host_connect_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/twowire_host_connect_gen.sv
// rtl/twowire_host_connect_gen.sv - host-side Two-Wire Debug Connect sequence generator
module twowire_host_connect_gen #(
    parameter int N_PREAMBLE = 8
) (
    input  logic       dck,
    input  logic       drst_n,
    input  logic       bit_en,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] target_addr,
    output logic       busy,
    output logic       done,
    output logic       dio_o,
    output logic       dio_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LFSR,
        S_ONES,
        S_ADDR
    } state_t;

    localparam logic [7:0] PRE_LAST  = 8'(N_PREAMBLE - 1);
    localparam logic [7:0] LFSR_LAST = 8'd63;
    localparam logic [7:0] ONES_LAST = 8'd71;
    localparam logic [7:0] ADDR_LAST = 8'd7;
    localparam logic [5:0] LFSR_SEED = 6'h29;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [5:0] lfsr, lfsr_n;
    logic [3:0] addr, addr_n;
    logic       done_n;
    logic       busy_n;
    logic       dio_n;
    logic       last;

    // Next-state logic plus the bit that will be visible on DIO after this edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lfsr_n  = lfsr;
        addr_n  = addr;
        done_n  = 1'b0;
        last    = 1'b0;
        busy_n  = 1'b0;
        dio_n   = 1'b0;

        case (state)
            S_PREAMBLE: last = (cnt == PRE_LAST);
            S_LFSR:     last = (cnt == LFSR_LAST);
            S_ONES:     last = (cnt == ONES_LAST);
            S_ADDR:     last = (cnt == ADDR_LAST);
            default:    last = 1'b0;
        endcase

        if (abort) begin
            // Abort wins over everything, including start in IDLE
            state_n = S_IDLE;
            cnt_n   = 8'd0;
            lfsr_n  = LFSR_SEED;
        end else if (state == S_IDLE) begin
            if (start) begin
                state_n = S_PREAMBLE;
                cnt_n   = 8'd0;
                lfsr_n  = LFSR_SEED;
                addr_n  = target_addr;
            end
        end else if (bit_en) begin
            if (last) begin
                cnt_n = 8'd0;
                case (state)
                    S_PREAMBLE: state_n = S_LFSR;
                    S_LFSR:     state_n = S_ONES;
                    S_ONES:     state_n = S_ADDR;
                    default: begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        lfsr_n  = LFSR_SEED;
                    end
                endcase
            end else begin
                cnt_n = cnt + 8'd1;
                if (state == S_LFSR) begin
                    lfsr_n = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
                end
            end
        end

        busy_n = (state_n != S_IDLE);

        // Address phase: MSB-first address, then its complement
        case (state_n)
            S_LFSR:  dio_n = lfsr_n[5];
            S_ONES:  dio_n = 1'b1;
            S_ADDR:  dio_n = cnt_n[2] ? ~addr_n[2'd3 - cnt_n[1:0]] : addr_n[2'd3 - cnt_n[1:0]];
            default: dio_n = 1'b0;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            lfsr   <= LFSR_SEED;
            addr   <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dio_o  <= 1'b0;
            dio_oe <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lfsr   <= lfsr_n;
            addr   <= addr_n;
            busy   <= busy_n;
            done   <= done_n;
            dio_o  <= dio_n;
            dio_oe <= busy_n;
        end
    end

endmodule

// File: tb/tb_twowire_host_connect_gen.sv
// tb/tb_twowire_host_connect_gen.sv - bench for twowire_host_connect_gen
module tb_twowire_host_connect_gen;

    logic       dck = 1'b0;
    logic       drst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] target_addr = 4'd0;
    logic       busy, done, dio_o, dio_oe;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];
    logic got[152];
    int busy_cyc;

    typedef struct {
        logic [3:0] addr;
        int         pct;
        logic [7:0] exp_addr;
        bit         mid;
    } vec_t;

    vec_t vecs[5];

    twowire_host_connect_gen #(.N_PREAMBLE(8)) dut (
        .dck(dck),
        .drst_n(drst_n),
        .bit_en(bit_en),
        .start(start),
        .abort(abort),
        .target_addr(target_addr),
        .busy(busy),
        .done(done),
        .dio_o(dio_o),
        .dio_oe(dio_oe)
    );

    always #5 dck = ~dck;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_q(input logic [7:0] ea);
        logic [5:0] l;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        l = 6'h29;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(l[5]);
            l = {l[4:0], l[5] ^ l[4]};
        end
        for (int i = 0; i < 72; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(ea[7-i]);
    endtask

    task automatic run_seq(input logic [3:0] a, input int pct, input logic [7:0] ea, input bit mid, input bit b2b);
        int   strobes = 0;
        int   guard = 0;
        int   idx = 0;
        logic held = 1'b0;
        bit   newb = 1'b1;
        bit   e;
        build_q(ea);
        @(negedge dck);
        start = 1'b1;
        target_addr = a;
        bit_en = ($urandom_range(99) < pct);
        @(negedge dck);
        start = 1'b0;
        busy_cyc = 0;
        while (strobes < 152 && guard < 5000) begin
            chk("busy_during_seq", busy, 1);
            chk("oe_during_seq", dio_oe, 1);
            busy_cyc++;
            if (newb) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bit%0d", idx), dio_o, e);
                    if (idx < 152) got[idx] = dio_o;
                    idx++;
                    held = dio_o;
                end
            end else begin
                chk("bit_hold", dio_o, held);
            end
            start = mid && (strobes == 50);
            target_addr = (mid && strobes >= 50) ? 4'hC : a;
            bit_en = ($urandom_range(99) < pct);
            newb = bit_en;
            if (bit_en) strobes++;
            @(negedge dck);
            guard++;
        end
        chk("seq_timeout", guard < 5000, 1);
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        chk("oe_after", dio_oe, 0);
        chk("dio_after", dio_o, 0);
        chk("queue_empty", exp_q.size(), 0);
        if (pct == 100) chk("busy_cycles", busy_cyc, 152);
        bit_en = 1'b0;
        start = 1'b0;
        if (b2b) begin
            start = 1'b1;
            target_addr = a;
        end
        @(negedge dck);
        chk("done_one_cycle", done, 0);
        if (b2b) begin
            chk("b2b_busy", busy, 1);
            chk("b2b_oe", dio_oe, 1);
            chk("b2b_preamble", dio_o, 0);
            start = 1'b0;
            abort = 1'b1;
            @(negedge dck);
            abort = 1'b0;
            chk("b2b_abort_idle", busy, 0);
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [5:0] lf;
        bit         saw_done;

        vecs[0] = '{addr: 4'h5, pct: 100, exp_addr: 8'h5A, mid: 1'b0};
        vecs[1] = '{addr: 4'hA, pct: 30,  exp_addr: 8'hA5, mid: 1'b0};
        vecs[2] = '{addr: 4'h3, pct: 100, exp_addr: 8'h3C, mid: 1'b1};
        vecs[3] = '{addr: 4'h0, pct: 50,  exp_addr: 8'h0F, mid: 1'b0};
        vecs[4] = '{addr: 4'hF, pct: 100, exp_addr: 8'hF0, mid: 1'b0};

        repeat (3) @(negedge dck);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dio", dio_o, 0);
        chk("rst_oe", dio_oe, 0);
        drst_n = 1'b1;
        repeat (2) @(negedge dck);

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].addr, vecs[v].pct, vecs[v].exp_addr, vecs[v].mid, 1'b0);
            if (v == 0) begin
                lf = {got[8], got[9], got[10], got[11], got[12], got[13]};
                chk("lfsr_first6", lf, 6'b101001);
                chk("lfsr_bit64", got[71], 1);
                for (int i = 0; i < 8; i++) rx[7-i] = got[144+i];
                chk("monitor_addr5_connect", rx == 8'h5A, 1);
                chk("monitor_addr6_no_connect", rx == 8'h69, 0);
            end
        end

        // start held across done gives back-to-back sequences
        run_seq(4'h5, 100, 8'h5A, 1'b0, 1'b1);

        // abort at bit 100 (ONES phase)
        @(negedge dck);
        start = 1'b1;
        target_addr = 4'h5;
        bit_en = 1'b1;
        @(negedge dck);
        start = 1'b0;
        repeat (100) @(negedge dck);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_bit", dio_o, 1);
        abort = 1'b1;
        @(negedge dck);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_oe", dio_oe, 0);
        chk("abort_dio", dio_o, 0);
        saw_done = done;
        repeat (4) begin
            @(negedge dck);
            saw_done = saw_done | done;
        end
        chk("abort_no_done", saw_done, 0);
        bit_en = 1'b0;
        run_seq(4'h5, 100, 8'h5A, 1'b0, 1'b0);

        // abort in IDLE blocks start
        @(negedge dck);
        start = 1'b1;
        abort = 1'b1;
        @(negedge dck);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_oe", dio_oe, 0);

        // asynchronous reset mid-LFSR
        @(negedge dck);
        start = 1'b1;
        target_addr = 4'h9;
        bit_en = 1'b1;
        @(negedge dck);
        start = 1'b0;
        repeat (30) @(negedge dck);
        chk("pre_reset_busy", busy, 1);
        #2 drst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_oe", dio_oe, 0);
        chk("async_rst_dio", dio_o, 0);
        chk("async_rst_done", done, 0);
        @(negedge dck);
        drst_n = 1'b1;
        repeat (3) @(negedge dck);
        chk("post_reset_idle", busy, 0);
        bit_en = 1'b0;
        run_seq(4'h9, 100, 8'h96, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
